// File: rtl/writeback.sv
// writeback: one holding slot per execution unit feeding a two-port register-file writer
// under rotating priority. Define WRITEBACK_BYPASS_EN to let incoming results compete the same cycle.
module writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu1_done,
  input  logic [5:0]  alu1_rd,
  input  logic [63:0] alu1_data,
  input  logic        alu2_done,
  input  logic [5:0]  alu2_rd,
  input  logic [63:0] alu2_data,
  input  logic        advint_done,
  input  logic [5:0]  advint_rd,
  input  logic [63:0] advint_data,
  input  logic [5:0]  advint_rd2,
  input  logic [63:0] advint_data2,
  input  logic        memunit_done,
  input  logic [5:0]  memunit_rd,
  input  logic [63:0] memunit_data,
  input  logic        branch_done,
  input  logic [5:0]  branch_rd,
  input  logic [63:0] branch_data,
  output logic        alu1_wb_full,
  output logic        alu2_wb_full,
  output logic        advint_wb_full,
  output logic        memunit_wb_full,
  output logic        branch_wb_full,
  output logic        wr1_en,
  output logic [5:0]  wr1_rn,
  output logic [63:0] wr1_data,
  output logic        wr2_en,
  output logic [5:0]  wr2_rn,
  output logic [63:0] wr2_data,
  output logic [5:0]  reg1_finished,
  output logic [5:0]  reg2_finished,
  output logic        wb_overflow
);

  localparam int NUNITS = 5;
  localparam int ADVINT = 2;
`ifdef WRITEBACK_BYPASS_EN
  localparam int NCAND = 2 * NUNITS;
`else
  localparam int NCAND = NUNITS;
`endif

  typedef struct packed {
    logic        avail;
    logic        dual;
    logic [5:0]  rn;
    logic [63:0] data;
    logic [5:0]  rn2;
    logic [63:0] data2;
  } cand_t;

  function automatic logic [2:0] unit_at(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] sum_v;
    sum_v = {1'b0, base} + {1'b0, off};
    return (sum_v >= 4'd5) ? 3'(sum_v - 4'd5) : 3'(sum_v);
  endfunction

  logic [NUNITS-1:0] done_s;
  logic [NUNITS-1:0] in_dest_s;
  logic [5:0]        in_rd_s   [NUNITS];
  logic [63:0]       in_data_s [NUNITS];

  logic [NUNITS-1:0] valid_r;
  logic [5:0]        rd_r   [NUNITS];
  logic [63:0]       data_r [NUNITS];
  logic [5:0]        rd2_r;
  logic [63:0]       data2_r;
  logic [2:0]        ptr_r;

  cand_t             slot_c_s [NUNITS];
  logic [NUNITS-1:0] slot_grant_s;
  logic [NUNITS-1:0] byp_grant_s;
  logic [NUNITS-1:0] busy_s;
  logic [NUNITS-1:0] load_s;
  logic              g1_s;
  logic              g2_s;
  logic [5:0]        p1_rn_s;
  logic [5:0]        p2_rn_s;
  logic [63:0]       p1_data_s;
  logic [63:0]       p2_data_s;
  logic [2:0]        last_s;

  logic              wr1_en_r;
  logic              wr2_en_r;
  logic [5:0]        wr1_rn_r;
  logic [5:0]        wr2_rn_r;
  logic [63:0]       wr1_data_r;
  logic [63:0]       wr2_data_r;
  logic [5:0]        reg1_fin_r;
  logic [5:0]        reg2_fin_r;
  logic              ovf_r;

  assign done_s       = {branch_done, memunit_done, advint_done, alu2_done, alu1_done};
  assign in_rd_s[0]   = alu1_rd;
  assign in_rd_s[1]   = alu2_rd;
  assign in_rd_s[2]   = advint_rd;
  assign in_rd_s[3]   = memunit_rd;
  assign in_rd_s[4]   = branch_rd;
  assign in_data_s[0] = alu1_data;
  assign in_data_s[1] = alu2_data;
  assign in_data_s[2] = advint_data;
  assign in_data_s[3] = memunit_data;
  assign in_data_s[4] = branch_data;

  // Describe each held slot as a candidate; advint with only rd2 set writes through port 1.
  always_comb begin
    for (int u = 0; u < NUNITS; u++) begin
      in_dest_s[u] = (in_rd_s[u] != 6'd0);
      slot_c_s[u]  = '{avail: valid_r[u], dual: 1'b0, rn: rd_r[u], data: data_r[u],
                       rn2: 6'd0, data2: 64'd0};
    end
    in_dest_s[ADVINT]      = (advint_rd != 6'd0) || (advint_rd2 != 6'd0);
    slot_c_s[ADVINT].dual  = (rd_r[ADVINT] != 6'd0) && (rd2_r != 6'd0);
    slot_c_s[ADVINT].rn    = (rd_r[ADVINT] != 6'd0) ? rd_r[ADVINT] : rd2_r;
    slot_c_s[ADVINT].data  = (rd_r[ADVINT] != 6'd0) ? data_r[ADVINT] : data2_r;
    slot_c_s[ADVINT].rn2   = rd2_r;
    slot_c_s[ADVINT].data2 = data2_r;
  end

`ifdef WRITEBACK_BYPASS_EN
  cand_t inc_c_s [NUNITS];

  // Incoming results are candidates only when their own slot is empty.
  always_comb begin
    for (int u = 0; u < NUNITS; u++) begin
      inc_c_s[u] = '{avail: done_s[u] && !valid_r[u] && in_dest_s[u], dual: 1'b0,
                     rn: in_rd_s[u], data: in_data_s[u], rn2: 6'd0, data2: 64'd0};
    end
    inc_c_s[ADVINT].dual  = (advint_rd != 6'd0) && (advint_rd2 != 6'd0);
    inc_c_s[ADVINT].rn    = (advint_rd != 6'd0) ? advint_rd : advint_rd2;
    inc_c_s[ADVINT].data  = (advint_rd != 6'd0) ? advint_data : advint_data2;
    inc_c_s[ADVINT].rn2   = advint_rd2;
    inc_c_s[ADVINT].data2 = advint_data2;
  end
`endif

  // Pick up to two writes scanning from the pointer; a dual advint must be first and takes both ports.
  always_comb begin
    cand_t      c_v;
    logic [2:0] u_v;
    logic       take_v;
    g1_s         = 1'b0;
    g2_s         = 1'b0;
    p1_rn_s      = 6'd0;
    p2_rn_s      = 6'd0;
    p1_data_s    = 64'd0;
    p2_data_s    = 64'd0;
    slot_grant_s = '0;
    byp_grant_s  = '0;
    last_s       = ptr_r;
    for (int k = 0; k < NCAND; k++) begin
      u_v    = unit_at(ptr_r, (k < NUNITS) ? 3'(k) : 3'(k - NUNITS));
`ifdef WRITEBACK_BYPASS_EN
      c_v    = (k < NUNITS) ? slot_c_s[u_v] : inc_c_s[u_v];
`else
      c_v    = slot_c_s[u_v];
`endif
      take_v = 1'b0;
      if (c_v.avail && !g1_s) begin
        take_v    = 1'b1;
        g1_s      = 1'b1;
        p1_rn_s   = c_v.rn;
        p1_data_s = c_v.data;
        g2_s      = c_v.dual;
        p2_rn_s   = c_v.dual ? c_v.rn2 : 6'd0;
        p2_data_s = c_v.dual ? c_v.data2 : 64'd0;
      end else if (c_v.avail && !g2_s && !c_v.dual && (c_v.rn != p1_rn_s)) begin
        take_v    = 1'b1;
        g2_s      = 1'b1;
        p2_rn_s   = c_v.rn;
        p2_data_s = c_v.data;
      end else begin
        take_v = 1'b0;
      end
      if (take_v) begin
        last_s = u_v;
`ifdef WRITEBACK_BYPASS_EN
        if (k < NUNITS) begin
          slot_grant_s[u_v] = 1'b1;
        end else begin
          byp_grant_s[u_v] = 1'b1;
        end
`else
        slot_grant_s[u_v] = 1'b1;
`endif
      end else begin
        last_s = last_s;
      end
    end
  end

  // A slot stays busy unless granted now, which is what lets a done reload it at the same edge.
  assign busy_s = valid_r & ~slot_grant_s;
  assign load_s = done_s & ~busy_s & in_dest_s & ~byp_grant_s;

  // Slot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      rd2_r   <= 6'd0;
      data2_r <= 64'd0;
      for (int u = 0; u < NUNITS; u++) begin
        rd_r[u]   <= 6'd0;
        data_r[u] <= 64'd0;
      end
    end else begin
      valid_r <= load_s | busy_s;
      for (int u = 0; u < NUNITS; u++) begin
        if (load_s[u]) begin
          rd_r[u]   <= in_rd_s[u];
          data_r[u] <= in_data_s[u];
        end
      end
      if (load_s[ADVINT]) begin
        rd2_r   <= advint_rd2;
        data2_r <= advint_data2;
      end
    end
  end

  // Write ports, priority pointer and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr1_en_r   <= 1'b0;
      wr2_en_r   <= 1'b0;
      wr1_rn_r   <= 6'd0;
      wr2_rn_r   <= 6'd0;
      wr1_data_r <= 64'd0;
      wr2_data_r <= 64'd0;
      reg1_fin_r <= 6'd0;
      reg2_fin_r <= 6'd0;
      ptr_r      <= 3'd0;
      ovf_r      <= 1'b0;
    end else begin
      wr1_en_r   <= g1_s;
      wr2_en_r   <= g2_s;
      wr1_rn_r   <= p1_rn_s;
      wr2_rn_r   <= p2_rn_s;
      wr1_data_r <= p1_data_s;
      wr2_data_r <= p2_data_s;
      reg1_fin_r <= g1_s ? p1_rn_s : 6'd0;
      reg2_fin_r <= g2_s ? p2_rn_s : 6'd0;
      ptr_r      <= g1_s ? unit_at(last_s, 3'd1) : ptr_r;
      ovf_r      <= ovf_r | (|(done_s & busy_s));
    end
  end

  assign alu1_wb_full    = valid_r[0];
  assign alu2_wb_full    = valid_r[1];
  assign advint_wb_full  = valid_r[2];
  assign memunit_wb_full = valid_r[3];
  assign branch_wb_full  = valid_r[4];
  assign wr1_en          = wr1_en_r;
  assign wr2_en          = wr2_en_r;
  assign wr1_rn          = wr1_rn_r;
  assign wr2_rn          = wr2_rn_r;
  assign wr1_data        = wr1_data_r;
  assign wr2_data        = wr2_data_r;
  assign reg1_finished   = reg1_fin_r;
  assign reg2_finished   = reg2_fin_r;
  assign wb_overflow     = ovf_r;

endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: directed scenarios plus random traffic against a write-list reference model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  done_v;
  logic [5:0]  rd_v  [5];
  logic [63:0] dat_v [5];
  logic [5:0]  rd2_v;
  logic [63:0] dat2_v;

  logic        alu1_wb_full, alu2_wb_full, advint_wb_full, memunit_wb_full, branch_wb_full;
  logic        wr1_en, wr2_en, wb_overflow;
  logic [5:0]  wr1_rn, wr2_rn, reg1_finished, reg2_finished;
  logic [63:0] wr1_data, wr2_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  writeback dut (
    .clk(clk), .rst_n(rst_n),
    .alu1_done(done_v[0]), .alu1_rd(rd_v[0]), .alu1_data(dat_v[0]),
    .alu2_done(done_v[1]), .alu2_rd(rd_v[1]), .alu2_data(dat_v[1]),
    .advint_done(done_v[2]), .advint_rd(rd_v[2]), .advint_data(dat_v[2]),
    .advint_rd2(rd2_v), .advint_data2(dat2_v),
    .memunit_done(done_v[3]), .memunit_rd(rd_v[3]), .memunit_data(dat_v[3]),
    .branch_done(done_v[4]), .branch_rd(rd_v[4]), .branch_data(dat_v[4]),
    .alu1_wb_full(alu1_wb_full), .alu2_wb_full(alu2_wb_full), .advint_wb_full(advint_wb_full),
    .memunit_wb_full(memunit_wb_full), .branch_wb_full(branch_wb_full),
    .wr1_en(wr1_en), .wr1_rn(wr1_rn), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_rn(wr2_rn), .wr2_data(wr2_data),
    .reg1_finished(reg1_finished), .reg2_finished(reg2_finished),
    .wb_overflow(wb_overflow)
  );

  // Reference model: held results, pointer, sticky flag and the writes expected after the next edge.
  bit          m_v [5];
  logic [5:0]  m_rd [5];
  logic [63:0] m_d [5];
  logic [5:0]  m_rd2;
  logic [63:0] m_d2;
  int          m_ptr;
  bit          m_ovf;
  logic [5:0]  e_rn [$];
  logic [63:0] e_d [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 5; u++) begin
      m_v[u] = 1'b0; m_rd[u] = 6'd0; m_d[u] = 64'd0;
    end
    m_rd2 = 6'd0; m_d2 = 64'd0; m_ptr = 0; m_ovf = 1'b0;
    e_rn.delete(); e_d.delete();
  endtask

  // Each candidate result is the list of register writes it carries; take lists greedily in scan order.
  task automatic model_step();
    int          ord_u [$];
    bit          ord_inc [$];
    bit          gr [5];
    bit          bg [5];
    logic [5:0]  cr [2];
    logic [63:0] cd [2];
    int          cn, last;
    bit          any, busy, has;
    any = 1'b0; last = 0;
    e_rn.delete(); e_d.delete();
    for (int u = 0; u < 5; u++) begin gr[u] = 1'b0; bg[u] = 1'b0; end
    for (int k = 0; k < 5; k++) begin
      if (m_v[(m_ptr + k) % 5]) begin ord_u.push_back((m_ptr + k) % 5); ord_inc.push_back(1'b0); end
    end
`ifdef WRITEBACK_BYPASS_EN
    for (int k = 0; k < 5; k++) begin
      int u;
      u = (m_ptr + k) % 5;
      if (done_v[u] && !m_v[u] && (rd_v[u] != 0 || (u == 2 && rd2_v != 0))) begin
        ord_u.push_back(u); ord_inc.push_back(1'b1);
      end
    end
`endif
    for (int i = 0; i < ord_u.size(); i++) begin
      int u;
      u = ord_u[i];
      cn = 0;
      if (ord_inc[i]) begin
        if (rd_v[u] != 0) begin cr[cn] = rd_v[u]; cd[cn] = dat_v[u]; cn++; end
        if (u == 2 && rd2_v != 0) begin cr[cn] = rd2_v; cd[cn] = dat2_v; cn++; end
      end else begin
        if (m_rd[u] != 0) begin cr[cn] = m_rd[u]; cd[cn] = m_d[u]; cn++; end
        if (u == 2 && m_rd2 != 0) begin cr[cn] = m_rd2; cd[cn] = m_d2; cn++; end
      end
      if (e_rn.size() == 0 || (e_rn.size() == 1 && cn == 1 && cr[0] != e_rn[0])) begin
        for (int j = 0; j < cn; j++) begin e_rn.push_back(cr[j]); e_d.push_back(cd[j]); end
        if (ord_inc[i]) bg[u] = 1'b1; else gr[u] = 1'b1;
        last = u; any = 1'b1;
      end
    end
    for (int u = 0; u < 5; u++) begin
      busy = m_v[u] && !gr[u];
      has  = (rd_v[u] != 0) || (u == 2 && rd2_v != 0);
      if (gr[u]) m_v[u] = 1'b0;
      if (done_v[u]) begin
        if (busy) m_ovf = 1'b1;
        else if (has && !bg[u]) begin
          m_v[u] = 1'b1; m_rd[u] = rd_v[u]; m_d[u] = dat_v[u];
          if (u == 2) begin m_rd2 = rd2_v; m_d2 = dat2_v; end
        end
      end
    end
    if (any) m_ptr = (last + 1) % 5;
  endtask

  task automatic check_outputs();
    logic [4:0] full_exp;
    full_exp = {m_v[4], m_v[3], m_v[2], m_v[1], m_v[0]};
    check("wr1_en", wr1_en, e_rn.size() >= 1);
    check("wr2_en", wr2_en, e_rn.size() >= 2);
    if (e_rn.size() >= 1) begin
      check("wr1_rn", wr1_rn, e_rn[0]);
      check("wr1_data", wr1_data, e_d[0]);
    end
    if (e_rn.size() >= 2) begin
      check("wr2_rn", wr2_rn, e_rn[1]);
      check("wr2_data", wr2_data, e_d[1]);
    end
    check("reg1_finished", reg1_finished, (e_rn.size() >= 1) ? e_rn[0] : 6'd0);
    check("reg2_finished", reg2_finished, (e_rn.size() >= 2) ? e_rn[1] : 6'd0);
    check("wb_full", {branch_wb_full, memunit_wb_full, advint_wb_full, alu2_wb_full, alu1_wb_full},
          full_exp);
    check("wb_overflow", wb_overflow, m_ovf);
  endtask

  task automatic clear_in();
    done_v = 5'd0;
    rd2_v  = 6'd0;
    dat2_v = 64'd0;
    for (int u = 0; u < 5; u++) begin rd_v[u] = 6'd0; dat_v[u] = 64'd0; end
  endtask

  task automatic pulse(input int u, input logic [5:0] rd, input logic [63:0] d);
    done_v[u] = 1'b1; rd_v[u] = rd; dat_v[u] = d;
  endtask

  // Inputs are set at a falling edge; the model and DUT both take them at the next rising edge.
  task automatic step();
    model_step();
    @(negedge clk);
    check_outputs();
    clear_in();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_in();
    model_reset();
    #1;
    check_outputs();
    check("reset_wr1_rn", wr1_rn, 6'd0);
    check("reset_wr1_data", wr1_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_in();
    model_reset();
    do_reset();

`ifndef WRITEBACK_BYPASS_EN
    // Single alu1 result: written two cycles after done.
    pulse(0, 6'd5, 64'h1234);
    step();
    check("r029_full", alu1_wb_full, 1'b1);
    step();
    check("r029_en", wr1_en, 1'b1);
    check("r029_rn", wr1_rn, 6'd5);
    check("r029_data", wr1_data, 64'h1234);
    check("r029_fin1", reg1_finished, 6'd5);
    check("r029_fin2", reg2_finished, 6'd0);

    // Pointer now at alu2: dual advint beats alu1 and takes both ports.
    pulse(2, 6'd7, 64'h7777); rd2_v = 6'd8; dat2_v = 64'h8888;
    pulse(0, 6'd4, 64'h4444);
    step();
    step();
    check("r031_rn1", wr1_rn, 6'd7);
    check("r031_rn2", wr2_rn, 6'd8);
    check("r031_d2", wr2_data, 64'h8888);
    step();
    check("r031_alu1", wr1_rn, 6'd4);
    check("r031_p2idle", wr2_en, 1'b0);

    // A store with no destination is never held.
    pulse(3, 6'd0, 64'hdead);
    step();
    check("r032_full", memunit_wb_full, 1'b0);
    step();
    check("r032_nowr", wr1_en, 1'b0);

    do_reset();
    pulse(0, 6'd1, 64'h11); pulse(1, 6'd2, 64'h22); pulse(3, 6'd3, 64'h33);
    step();
    check("r030_mem_c1", memunit_wb_full, 1'b1);
    step();
    check("r030_rn1", wr1_rn, 6'd1);
    check("r030_rn2", wr2_rn, 6'd2);
    check("r030_mem_c2", memunit_wb_full, 1'b1);
    step();
    check("r030_rn3", wr1_rn, 6'd3);
    check("r030_mem_c3", memunit_wb_full, 1'b0);

    // Same destination defers alu2, so a second alu2 done hits a full slot.
    pulse(0, 6'd9, 64'h90); pulse(1, 6'd9, 64'h91);
    step();
    pulse(1, 6'd10, 64'ha0);
    step();
    check("r033_ovf", wb_overflow, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check("r033_sticky", wb_overflow, 1'b1);
    do_reset();
    check("r033_cleared", wb_overflow, 1'b0);
`else
    pulse(4, 6'd63, 64'hbeef);
    step();
    check("r034_en", wr1_en, 1'b1);
    check("r034_rn", wr1_rn, 6'd63);
    check("r034_full", branch_wb_full, 1'b0);
    step();
    check("r034_full_after", branch_wb_full, 1'b0);
`endif

    // Random legal traffic, with an asynchronous reset in the middle.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        do_reset();
        for (int i = 0; i < 3; i++) step();
      end
      for (int u = 0; u < 5; u++) begin
        if (!m_v[u] && $urandom_range(0, 99) < 45) begin
          pulse(u, 6'($urandom_range(0, 12)), {$urandom, $urandom});
        end
      end
      if (done_v[2] && $urandom_range(0, 1) == 1) begin
        rd2_v  = 6'($urandom_range(0, 12));
        dat2_v = {$urandom, $urandom};
        if (rd2_v == rd_v[2]) rd2_v = 6'd0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
